fpu_div: RTL

FPU_DIV -- requirements
Module: fpu_div

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_div_core.sv | 63 ++++++
 rtl/fpu_div.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared constants, FSM state encoding and status-flag bundle for the
// iterative binary64 divider.
package fpu_pkg;

    localparam int unsigned BIAS      = 1023;
    localparam int unsigned EXP_MAX   = 2047;
    localparam int unsigned DIV_STEPS = 55;

    localparam int unsigned EXP_W  = 11;
    localparam int unsigned FRAC_W = 52;
    localparam int unsigned MANT_W = FRAC_W + 1;   // significand with hidden one
    localparam int unsigned QUOT_W = DIV_STEPS;    // one quotient bit per step
    localparam int unsigned CNT_W  = 6;            // holds 0..DIV_STEPS-1
    localparam int unsigned EXPC_W = 13;           // signed working exponent

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
        logic div_by_zero;
    } fpu_flags_t;

endpackage

// File: rtl/fpu_div_core.sv
// Restoring radix-2 significand divider, one quotient bit per i_step.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_load          capture dividend/divisor, clear quotient and step counter
//   i_step          perform one restoring-division step
//   i_dividend      53-bit dividend significand {1,frac}
//   i_divisor       53-bit divisor significand {1,frac}
//   o_quot          quotient bits, MSB first shifted in
//   o_rem           running (shifted) remainder
//   o_last          high while the step about to be taken is the final one
module fpu_div_core
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [MANT_W-1:0] i_dividend,
    input  logic [MANT_W-1:0] i_divisor,
    output logic [QUOT_W-1:0] o_quot,
    output logic [QUOT_W-1:0] o_rem,
    output logic              o_last
);

    logic [QUOT_W-1:0] r_rem;
    logic [QUOT_W-1:0] r_quot;
    logic [MANT_W-1:0] r_divisor;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;

    logic              w_ge;
    logic [QUOT_W-1:0] w_rem_sel;

    // Remainder stays below twice the divisor, so the left shift never loses a bit.
    assign w_ge      = r_rem >= QUOT_W'(r_divisor);
    assign w_rem_sel = w_ge ? (r_rem - QUOT_W'(r_divisor)) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_last    <= 1'b0;
        end else if (i_load) begin
            r_rem     <= QUOT_W'(i_dividend);
            r_quot    <= '0;
            r_divisor <= i_divisor;
            r_cnt     <= '0;
            r_last    <= (DIV_STEPS == 1);
        end else if (i_step) begin
            r_quot <= {r_quot[QUOT_W-2:0], w_ge};
            r_rem  <= {w_rem_sel[QUOT_W-2:0], 1'b0};
            r_cnt  <= r_cnt + CNT_W'(1);
            r_last <= (r_cnt == CNT_W'(DIV_STEPS - 2));
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = r_last;

endmodule

// File: rtl/fpu_div.sv
// Multi-cycle IEEE-754 binary64 divider: special-case screening, iterative
// significand division, normalisation and guard/sticky rounding.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request a/b, sampled only in IDLE
//   a, b              binary64 dividend / divisor
//   busy              high in every state except IDLE
//   done              one-cycle pulse when result/flags are valid
//   result            quotient, held until the next accepted start
//   Exception, Overflow, Underflow, DivByZero   mutually exclusive status flags
module fpu_div
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    state_t      r_state;
    logic [63:0] r_a;
    logic [63:0] r_b;
    fpu_flags_t  r_flags;

    logic              w_sign;
    logic [EXP_W-1:0]  w_ea;
    logic [EXP_W-1:0]  w_eb;
    logic [QUOT_W-1:0] w_q;
    logic [QUOT_W-1:0] w_rem;
    logic              w_core_last;

    assign w_sign = r_a[63] ^ r_b[63];
    assign w_ea   = r_a[62:52];
    assign w_eb   = r_b[62:52];

    fpu_div_core u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == CHECK),
        .i_step     (r_state == DIV),
        .i_dividend ({1'b1, r_a[FRAC_W-1:0]}),
        .i_divisor  ({1'b1, r_b[FRAC_W-1:0]}),
        .o_quot     (w_q),
        .o_rem      (w_rem),
        .o_last     (w_core_last)
    );

    // Special-operand screening; NaN/Inf inputs dominate, 0/0 resolves to zero.
    logic        w_special;
    logic [63:0] w_spec_result;
    fpu_flags_t  w_spec_flags;

    always_comb begin
        w_special     = 1'b1;
        w_spec_result = '0;
        w_spec_flags  = '0;
        if (w_ea == EXP_W'(EXP_MAX) || w_eb == EXP_W'(EXP_MAX)) begin
            w_spec_flags.exception = 1'b1;
        end else if (w_ea == '0) begin
            w_spec_result = {w_sign, 63'd0};
        end else if (w_eb == '0) begin
            w_spec_flags.div_by_zero = 1'b1;
            w_spec_result            = {w_sign, EXP_W'(EXP_MAX), FRAC_W'(0)};
        end else begin
            w_special = 1'b0;
        end
    end

    // Normalise the 55-bit quotient, round on guard&sticky, range-check exponent.
    logic              w_hi;
    logic              w_guard;
    logic              w_sticky;
    logic              w_carry;
    logic [FRAC_W-1:0] w_mant;
    logic [MANT_W-1:0] w_mant_sum;
    logic [EXPC_W-1:0] w_exp_base;
    logic [EXPC_W-1:0] w_exp_fin;
    logic [63:0]       w_norm_result;
    fpu_flags_t        w_norm_flags;

    always_comb begin
        w_hi          = w_q[QUOT_W-1];
        w_mant        = w_q[QUOT_W-3:1];
        w_guard       = w_q[0];
        w_sticky      = |w_rem;
        w_exp_base    = EXPC_W'(w_ea) - EXPC_W'(w_eb) + EXPC_W'(BIAS - 1);
        if (w_hi) begin
            w_mant     = w_q[QUOT_W-2:2];
            w_guard    = w_q[1];
            w_sticky   = w_q[0] | (|w_rem);
            w_exp_base = EXPC_W'(w_ea) - EXPC_W'(w_eb) + EXPC_W'(BIAS);
        end
        w_mant_sum = {1'b0, w_mant} + MANT_W'(w_guard & w_sticky);
        // On carry the low 52 bits are already zero.
        w_carry    = w_mant_sum[MANT_W-1];
        w_exp_fin  = w_exp_base + EXPC_W'(w_carry);

        w_norm_flags  = '0;
        w_norm_result = {w_sign, w_exp_fin[EXP_W-1:0], w_mant_sum[FRAC_W-1:0]};
        // Top bit of the 13-bit exponent is its sign.
        if (!w_exp_fin[EXPC_W-1] && w_exp_fin >= EXPC_W'(EXP_MAX)) begin
            w_norm_flags.overflow = 1'b1;
            w_norm_result         = {w_sign, EXP_W'(EXP_MAX), FRAC_W'(0)};
        end else if (w_exp_fin[EXPC_W-1] || w_exp_fin == '0) begin
            w_norm_flags.underflow = 1'b1;
            w_norm_result          = {w_sign, 63'd0};
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_flags <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_flags <= '0;
                        result  <= '0;
                        busy    <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_special) begin
                        result  <= w_spec_result;
                        r_flags <= w_spec_flags;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    if (w_core_last) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    result  <= w_norm_result;
                    r_flags <= w_norm_flags;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Exception = r_flags.exception;
    assign Overflow  = r_flags.overflow;
    assign Underflow = r_flags.underflow;
    assign DivByZero = r_flags.div_by_zero;

endmodule
